regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised register file with a 2-read/1-write port set, registered (1-cycle) reads with write-through bypass, an optional hardwired-zero R0, and a per-register pending scoreboard for load-use hazard detection. After reset, a built-in clear sequencer zeroes every entry. Sits between decode and the exec stage register. It replaces the unclocked-read register file, so the exec stage no longer depends on an inverted BRAM read clock.

Parameters:
AWIDTH, 4, register index width; depth = 2^AWIDTH entries
DWIDTH, 16, data width in bits
ZERO_R0, 1, 1 = index 0 always reads 0, ignores writes, is never pending

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
asel  input  AWIDTH  read port A index
bsel  input  AWIDTH  read port B index
adata  output  DWIDTH  port A data, registered
bdata  output  DWIDTH  port B data, registered
a_ready  output  1  port A operand not pending, registered with adata
b_ready  output  1  port B operand not pending, registered with bdata
wsel  input  AWIDTH  write index
wdata  input  DWIDTH  write data
wreg  input  1  write enable; also clears pending[wsel]
msel  input  AWIDTH  scoreboard mark index
mark  input  1  set pending[msel] (an outstanding producer has issued)
busy  output  1  clear sequence in progress
pending_any  output  1  OR of all pending bits, registered

Behaviour:
- Reset (async assert) sets: state=CLEAR, clr_idx=0, busy=1, adata=bdata=0, a_ready=b_ready=0, pending all 0, pending_any=0. Array contents are not reset directly; the sequencer clears them.
- CLEAR state:
  - Each cycle, writes 0 to R[clr_idx] and increments clr_idx.
  - On the cycle clr_idx == 2^AWIDTH-1, the next state is RUN.
  - busy is high for exactly 2^AWIDTH cycles after reset deasserts.
  - wreg and mark are ignored.
  - adata, bdata, a_ready and b_ready are held at 0.
- RUN state (busy=0):
  - Write: if wreg, R[wsel] <= wdata. If ZERO_R0=1 and wsel=0, the write is dropped.
  - Read latency is 1 cycle. At the edge, adata <= (wreg && wsel==asel) ? wdata : R[asel]; port B is identical with bsel.
  - If ZERO_R0=1 and asel=0, adata <= 0 regardless of bypass.
  - a_ready <= !pending[asel] || (wreg && wsel==asel). The same-cycle write clears the hazard; a same-cycle mark is not visible until the next cycle. ZERO_R0 with index 0 gives ready=1. Port B is identical.
  - Scoreboard: pending[wsel] is cleared on wreg, and pending[msel] is set on mark.
    - Different indices in the same cycle: both updates apply.
    - Same index in the same cycle: mark wins, so pending stays 1 (a new producer is issued).
    - mark on an already-pending entry leaves it 1.
    - wreg on a non-pending entry leaves it 0.
  - pending_any <= OR of the next-state pending vector.
- asel == bsel is legal; both ports return identical values.
- Reset asserted mid-operation (in either state) returns the block to CLEAR and clears all pending bits. Any in-flight write is lost.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
- Reset pulse with AWIDTH=4: busy high for exactly 16 cycles. Every asel 0..15 then returns adata=0 with a_ready=1.
- Write R3=0x1234, then read asel=3: adata=0x1234 one cycle later. With wreg, wsel=5, wdata=0xBEEF and asel=5 in the same cycle: adata=0xBEEF on the next cycle (bypass).
- ZERO_R0=1: write wsel=0, wdata=0xFFFF, then read asel=0: adata=0, a_ready=1. With mark, msel=0: pending_any stays 0.
- Scoreboard hazard path:
  - mark, msel=7, then read asel=7: a_ready=0, pending_any=1.
  - wreg, wsel=7, wdata=0x55 with asel=7 in the same cycle: a_ready=1, adata=0x55.
  - Next cycle: pending_any=0.
- Scoreboard conflicts:
  - Same cycle mark, msel=2 and wreg, wsel=2: pending[2] stays 1, so a later read of 2 gives b_ready=0.
  - Same cycle mark, msel=4 and wreg, wsel=9, with 9 previously pending: pending[4]=1 and pending[9]=0.
- Assert reset during RUN with pending[6]=1 and R6=0xAAAA:
  - busy reasserts for 16 cycles.
  - Afterwards, a read of 6 gives 0 with a_ready=1, and pending_any=0.
  - wreg during CLEAR has no effect.

Source files
------------

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// regfile_sb_if : read/write/scoreboard signal bundle for regfile_sb
// Revision      : 1.0
// ============================================================================
interface regfile_sb_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 16
);
  logic [AWIDTH-1:0] asel;
  logic [AWIDTH-1:0] bsel;
  logic [DWIDTH-1:0] adata;
  logic [DWIDTH-1:0] bdata;
  logic              a_ready;
  logic              b_ready;
  logic [AWIDTH-1:0] wsel;
  logic [DWIDTH-1:0] wdata;
  logic              wreg;
  logic [AWIDTH-1:0] msel;
  logic              mark;
  logic              busy;
  logic              pending_any;

  modport master (
    output asel, bsel, wsel, wdata, wreg, msel, mark,
    input  adata, bdata, a_ready, b_ready, busy, pending_any
  );

  modport slave (
    input  asel, bsel, wsel, wdata, wreg, msel, mark,
    output adata, bdata, a_ready, b_ready, busy, pending_any
  );
endinterface
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : 2R/1W register file, registered reads with write bypass,
//              optional zero R0, load-use pending scoreboard, clear-on-reset.
// Revision   : 1.0
// ============================================================================
module regfile_sb #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 16,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [AWIDTH-1:0]   clr_idx;
  logic [AWIDTH-1:0]   clr_idx_next;
  logic [DWIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pending;
  logic [DEPTH-1:0]    pending_next;

  logic                mem_we;
  logic [AWIDTH-1:0]   mem_waddr;
  logic [DWIDTH-1:0]   mem_wdata;

  logic                a_zero;
  logic                b_zero;
  logic                w_zero;
  logic                m_zero;
  logic                a_hit;
  logic                b_hit;

  logic [DWIDTH-1:0]   adata_next;
  logic [DWIDTH-1:0]   bdata_next;
  logic                a_ready_next;
  logic                b_ready_next;

  generate
    if (ZERO_R0) begin : g_zero_r0
      assign a_zero = (bus.asel == '0);
      assign b_zero = (bus.bsel == '0);
      assign w_zero = (bus.wsel == '0);
      assign m_zero = (bus.msel == '0);
    end else begin : g_plain_r0
      assign a_zero = 1'b0;
      assign b_zero = 1'b0;
      assign w_zero = 1'b0;
      assign m_zero = 1'b0;
    end
  endgenerate

  assign a_hit = bus.wreg && (bus.wsel == bus.asel);
  assign b_hit = bus.wreg && (bus.wsel == bus.bsel);

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    mem_we       = 1'b0;
    mem_waddr    = bus.wsel;
    mem_wdata    = bus.wdata;
    pending_next = pending;
    adata_next   = '0;
    bdata_next   = '0;
    a_ready_next = 1'b0;
    b_ready_next = 1'b0;

    case (state)
      CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_idx;
        mem_wdata    = '0;
        clr_idx_next = clr_idx + AWIDTH'(1);
        if (&clr_idx) begin
          state_next = RUN;
        end
      end

      RUN: begin
        mem_we = bus.wreg && !w_zero;

        // Clear before set so a same-cycle retire+issue on one index stays pending
        if (bus.wreg) begin
          pending_next[bus.wsel] = 1'b0;
        end
        if (bus.mark && !m_zero) begin
          pending_next[bus.msel] = 1'b1;
        end

        adata_next   = a_zero ? '0 : (a_hit ? bus.wdata : mem[bus.asel]);
        bdata_next   = b_zero ? '0 : (b_hit ? bus.wdata : mem[bus.bsel]);
        a_ready_next = a_zero || !pending[bus.asel] || a_hit;
        b_ready_next = b_zero || !pending[bus.bsel] || b_hit;
      end

      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= CLEAR;
      clr_idx         <= '0;
      pending         <= '0;
      bus.pending_any <= 1'b0;
      bus.adata       <= '0;
      bus.bdata       <= '0;
      bus.a_ready     <= 1'b0;
      bus.b_ready     <= 1'b0;
    end else begin
      state           <= state_next;
      clr_idx         <= clr_idx_next;
      pending         <= pending_next;
      bus.pending_any <= |pending_next;
      bus.adata       <= adata_next;
      bus.bdata       <= bdata_next;
      bus.a_ready     <= a_ready_next;
      bus.b_ready     <= b_ready_next;
    end
  end

  // Storage is zeroed by the sequencer rather than by reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.busy = (state == CLEAR);

endmodule
`default_nettype wire
